blackjack_round_ctrl: RTL and testbench

Round sequencer for the blackjack game. It deals the opening four cards and runs the player hit/stand phase, then the dealer draw-to-17 phase, and produces the final result. It pulls cards from the card source over a request/valid handshake, keeps both hand totals with soft-ace handling, and drives the `turn`/`p_done` pair that the player/dealer display selector uses to choose which hand is shown.

---
 rtl/blackjack_pkg.sv | 42 ++++
 rtl/blackjack_round_ctrl_hand_accum.sv | 45 ++++
 rtl/blackjack_round_ctrl.sv | 135 +++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// ============================================================================
//  Module   : blackjack_pkg
//  Purpose  : Shared round states, result codes and card valuation.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package blackjack_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEAL_P1 = 4'd1,
    ST_DEAL_D1 = 4'd2,
    ST_DEAL_P2 = 4'd3,
    ST_DEAL_D2 = 4'd4,
    ST_PLAYER  = 4'd5,
    ST_P_DRAW  = 4'd6,
    ST_DEALER  = 4'd7,
    ST_D_DRAW  = 4'd8,
    ST_RESOLVE = 4'd9,
    ST_DONE    = 4'd10
  } round_state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam int BJ_MAX       = 21;
  localparam int DEALER_STAND = 17;

  // Ace counts 1 here; the soft +10 is applied by the hand accumulator.
  function automatic logic [4:0] rank_value(input logic [3:0] rank);
    if (rank >= 4'd10) begin
      return 5'd10;
    end
    return {1'b0, rank};
  endfunction

endpackage

`default_nettype wire

// File: rtl/blackjack_round_ctrl_hand_accum.sv
// ============================================================================
//  Module   : hand_accum
//  Purpose  : One hand: hard sum plus ace flag, reporting best total and bust.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hand_accum
  import blackjack_pkg::rank_value;
#(
  parameter int BJ_MAX = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] rank,
  output logic [4:0] total,
  output logic       bust
);

  localparam logic [4:0] c_bj_max = 5'(BJ_MAX);

  logic [4:0] r_hard_sum;
  logic       r_ace_seen;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hard_sum <= 5'd0;
      r_ace_seen <= 1'b0;
    end else if (add) begin
      r_hard_sum <= r_hard_sum + rank_value(rank);
      if (rank == 4'd1) begin
        r_ace_seen <= 1'b1;
      end
    end
  end

  // One ace may count 11 only while that keeps the hand at or below 21.
  assign total = (r_ace_seen && (r_hard_sum <= 5'd11)) ? (r_hard_sum + 5'd10) : r_hard_sum;
  assign bust  = (total > c_bj_max);

endmodule

`default_nettype wire

// File: rtl/blackjack_round_ctrl.sv
// ============================================================================
//  Module   : blackjack_round_ctrl
//  Purpose  : Deal, player hit/stand, dealer draw-to-stand and result resolve.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module blackjack_round_ctrl
  import blackjack_pkg::*;
#(
  parameter int STAND_AT = blackjack_pkg::DEALER_STAND,
  parameter int BJ_MAX   = blackjack_pkg::BJ_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic       card_valid,
  input  logic [3:0] card_rank,
  output logic       card_req,
  output logic       turn,
  output logic       p_done,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [1:0] result,
  output logic       round_done
);

  localparam logic [4:0] c_bj_max   = 5'(BJ_MAX);
  localparam logic [4:0] c_stand_at = 5'(STAND_AT);

  round_state_t r_state;
  round_state_t w_next;
  logic [1:0]   r_result;
  logic [1:0]   w_verdict;
  logic         r_p_done;
  logic         w_accept;
  logic         w_clear;
  logic         w_p_add;
  logic         w_d_add;
  logic         w_p_bust;
  logic         w_d_bust;

  assign card_req = (r_state == ST_DEAL_P1) || (r_state == ST_DEAL_D1) ||
                    (r_state == ST_DEAL_P2) || (r_state == ST_DEAL_D2) ||
                    (r_state == ST_P_DRAW)  || (r_state == ST_D_DRAW);
  assign w_accept = card_req && card_valid;
  assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_p_add  = w_accept && ((r_state == ST_DEAL_P1) || (r_state == ST_DEAL_P2) ||
                                 (r_state == ST_P_DRAW));
  assign w_d_add  = w_accept && ((r_state == ST_DEAL_D1) || (r_state == ST_DEAL_D2) ||
                                 (r_state == ST_D_DRAW));

  hand_accum #(.BJ_MAX(BJ_MAX)) u_player_hand (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .add   (w_p_add),
    .rank  (card_rank),
    .total (player_total),
    .bust  (w_p_bust)
  );

  hand_accum #(.BJ_MAX(BJ_MAX)) u_dealer_hand (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .add   (w_d_add),
    .rank  (card_rank),
    .total (dealer_total),
    .bust  (w_d_bust)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_DEAL_P1;
      ST_DEAL_P1:       if (w_accept) w_next = ST_DEAL_D1;
      ST_DEAL_D1:       if (w_accept) w_next = ST_DEAL_P2;
      ST_DEAL_P2:       if (w_accept) w_next = ST_DEAL_D2;
      ST_DEAL_D2:       if (w_accept) w_next = ST_PLAYER;
      ST_PLAYER: begin
        // Stand outranks hit when both arrive together.
        if (w_p_bust)                      w_next = ST_RESOLVE;
        else if (player_total == c_bj_max) w_next = ST_DEALER;
        else if (stand)                    w_next = ST_DEALER;
        else if (hit)                      w_next = ST_P_DRAW;
      end
      ST_P_DRAW:        if (w_accept) w_next = ST_PLAYER;
      ST_DEALER:        w_next = (dealer_total < c_stand_at) ? ST_D_DRAW : ST_RESOLVE;
      ST_D_DRAW:        if (w_accept) w_next = ST_DEALER;
      ST_RESOLVE:       w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_verdict = RES_PUSH;
    if (w_p_bust)                          w_verdict = RES_DEALER;
    else if (w_d_bust)                     w_verdict = RES_PLAYER;
    else if (player_total > dealer_total)  w_verdict = RES_PLAYER;
    else if (player_total < dealer_total)  w_verdict = RES_DEALER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= RES_NONE;
      r_p_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_result <= RES_NONE;
        r_p_done <= 1'b0;
      end else begin
        if ((r_state == ST_PLAYER) && ((w_next == ST_DEALER) || (w_next == ST_RESOLVE))) begin
          r_p_done <= 1'b1;
        end
        if (r_state == ST_RESOLVE) begin
          r_result <= w_verdict;
        end
      end
    end
  end

  assign turn       = (r_state == ST_DEALER) || (r_state == ST_D_DRAW) ||
                      (r_state == ST_RESOLVE) || (r_state == ST_DONE);
  assign p_done     = r_p_done;
  assign result     = r_result;
  assign round_done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_blackjack_round_ctrl.sv
// ============================================================================
//  Module   : tb_blackjack_round_ctrl
//  Purpose  : Directed scenario bench for the blackjack round sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_blackjack_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_rank = 4'd0;
  logic       card_req;
  logic       turn;
  logic       p_done;
  logic [4:0] player_total;
  logic [4:0] dealer_total;
  logic [1:0] result;
  logic       round_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blackjack_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .hit          (hit),
    .stand        (stand),
    .card_valid   (card_valid),
    .card_rank    (card_rank),
    .card_req     (card_req),
    .turn         (turn),
    .p_done       (p_done),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .result       (result),
    .round_done   (round_done)
  );

  // All stimulus tasks begin and end just after a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic deliver(input logic [3:0] rank);
    int n = 0;
    while (!card_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (card_req !== 1'b1) begin
      errors++;
      $display("FAIL deliver_wait: card_req=%b required 1", card_req);
    end
    card_valid = 1'b1;
    card_rank  = rank;
    @(negedge clk);
    card_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!round_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (round_done !== 1'b1) begin
      errors++;
      $display("FAIL round_done_wait: round_done=%b required 1", round_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hit   = (i % 3 == 0);
      stand = (i % 3 == 1);
      @(negedge clk);
      checks++;
      if ({card_req, turn, p_done, player_total, dealer_total, result, round_done} !== 16'd0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: req=%b turn=%b pd=%b pt=%0d dt=%0d res=%b done=%b required all 0",
                 i, card_req, turn, p_done, player_total, dealer_total, result, round_done);
      end
    end
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  task automatic test_stand_dealer_21();
    pulse_start();
    deliver(4'd10); deliver(4'd6); deliver(4'd7); deliver(4'd10);
    checks++;
    if (player_total !== 5'd17 || dealer_total !== 5'd16 || turn !== 1'b0 || p_done !== 1'b0) begin
      errors++;
      $display("FAIL deal1_totals: pt=%0d dt=%0d turn=%b pd=%b required 17 16 0 0",
               player_total, dealer_total, turn, p_done);
    end
    stand = 1'b1;
    @(negedge clk);
    stand = 1'b0;
    checks++;
    if (turn !== 1'b1 || p_done !== 1'b1) begin
      errors++;
      $display("FAIL stand_turn: turn=%b pd=%b required 1 1", turn, p_done);
    end
    deliver(4'd5);
    wait_done();
    checks++;
    if (result !== 2'b10 || dealer_total !== 5'd21 || player_total !== 5'd17) begin
      errors++;
      $display("FAIL dealer21_result: res=%b dt=%0d pt=%0d required 10 21 17",
               result, dealer_total, player_total);
    end
  endtask

  task automatic test_soft21_autostand();
    pulse_start();
    checks++;
    if (player_total !== 5'd0 || dealer_total !== 5'd0 || result !== 2'b00 || p_done !== 1'b0 ||
        turn !== 1'b0 || round_done !== 1'b0 || card_req !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: pt=%0d dt=%0d res=%b pd=%b turn=%b done=%b req=%b required 0 0 00 0 0 0 1",
               player_total, dealer_total, result, p_done, turn, round_done, card_req);
    end
    deliver(4'd1); deliver(4'd9); deliver(4'd13); deliver(4'd7);
    checks++;
    if (player_total !== 5'd21 || dealer_total !== 5'd16) begin
      errors++;
      $display("FAIL soft21_totals: pt=%0d dt=%0d required 21 16", player_total, dealer_total);
    end
    @(negedge clk);
    checks++;
    if (turn !== 1'b1 || p_done !== 1'b1) begin
      errors++;
      $display("FAIL autostand: turn=%b pd=%b required 1 1", turn, p_done);
    end
    deliver(4'd2);
    wait_done();
    checks++;
    if (result !== 2'b01 || dealer_total !== 5'd18) begin
      errors++;
      $display("FAIL soft21_result: res=%b dt=%0d required 01 18", result, dealer_total);
    end
  endtask

  task automatic test_player_bust();
    pulse_start();
    deliver(4'd10); deliver(4'd10); deliver(4'd6); deliver(4'd7);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    checks++;
    if (card_req !== 1'b1) begin
      errors++;
      $display("FAIL hit_req: card_req=%b required 1", card_req);
    end
    deliver(4'd9);
    checks++;
    if (player_total !== 5'd25 || card_req !== 1'b0) begin
      errors++;
      $display("FAIL bust_total: pt=%0d req=%b required 25 0", player_total, card_req);
    end
    @(negedge clk);
    checks++;
    if (p_done !== 1'b1 || turn !== 1'b1 || card_req !== 1'b0 || round_done !== 1'b0) begin
      errors++;
      $display("FAIL bust_resolve: pd=%b turn=%b req=%b done=%b required 1 1 0 0",
               p_done, turn, card_req, round_done);
    end
    @(negedge clk);
    checks++;
    if (round_done !== 1'b1 || result !== 2'b10 || dealer_total !== 5'd17) begin
      errors++;
      $display("FAIL bust_result: done=%b res=%b dt=%0d required 1 10 17", round_done, result, dealer_total);
    end
  endtask

  task automatic test_slow_source();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_req !== 1'b1 || player_total !== 5'd0) begin
        errors++;
        $display("FAIL slow_hold cycle %0d: req=%b pt=%0d required 1 0", i, card_req, player_total);
      end
      @(negedge clk);
    end
    deliver(4'd5);
    checks++;
    if (player_total !== 5'd5 || dealer_total !== 5'd0 || card_req !== 1'b1) begin
      errors++;
      $display("FAIL slow_one_card: pt=%0d dt=%0d req=%b required 5 0 1", player_total, dealer_total, card_req);
    end
    deliver(4'd3); deliver(4'd4); deliver(4'd10);
    card_valid = 1'b1;
    card_rank  = 4'd10;
    @(negedge clk);
    card_valid = 1'b0;
    checks++;
    if (player_total !== 5'd9 || dealer_total !== 5'd13) begin
      errors++;
      $display("FAIL stray_valid: pt=%0d dt=%0d required 9 13", player_total, dealer_total);
    end
    hit   = 1'b1;
    stand = 1'b1;
    @(negedge clk);
    hit   = 1'b0;
    stand = 1'b0;
    checks++;
    if (turn !== 1'b1 || p_done !== 1'b1 || card_req !== 1'b0 || player_total !== 5'd9) begin
      errors++;
      $display("FAIL hit_stand_tie: turn=%b pd=%b req=%b pt=%0d required 1 1 0 9",
               turn, p_done, card_req, player_total);
    end
    deliver(4'd10);
    wait_done();
    checks++;
    if (result !== 2'b01 || dealer_total !== 5'd23) begin
      errors++;
      $display("FAIL dealer_bust: res=%b dt=%0d required 01 23", result, dealer_total);
    end
  endtask

  task automatic test_reset_mid_draw();
    int n = 0;
    pulse_start();
    deliver(4'd10); deliver(4'd6); deliver(4'd10); deliver(4'd2);
    stand = 1'b1;
    @(negedge clk);
    stand = 1'b0;
    while (!card_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (card_req !== 1'b1 || dealer_total !== 5'd8) begin
      errors++;
      $display("FAIL ddraw_reached: req=%b dt=%0d required 1 8", card_req, dealer_total);
    end
    rst        = 1'b1;
    card_valid = 1'b1;
    card_rank  = 4'd10;
    @(negedge clk);
    rst        = 1'b0;
    card_valid = 1'b0;
    checks++;
    if ({card_req, turn, p_done, player_total, dealer_total, result, round_done} !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: req=%b turn=%b pd=%b pt=%0d dt=%0d res=%b done=%b required all 0",
               card_req, turn, p_done, player_total, dealer_total, result, round_done);
    end
    @(negedge clk);
    checks++;
    if (card_req !== 1'b0 || dealer_total !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_idle: req=%b dt=%0d required 0 0", card_req, dealer_total);
    end
    pulse_start();
    checks++;
    if (card_req !== 1'b1 || player_total !== 5'd0 || turn !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_reset: req=%b pt=%0d turn=%b required 1 0 0", card_req, player_total, turn);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stand_dealer_21();
    test_soft21_autostand();
    test_player_bust();
    test_slow_source();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
